// File: rtl/uart_rx_ctrl.sv
// UART receiver: start detect, 3-sample majority vote per bit, LSB-first deserialize, parity/stop check.
// Define RX_SYNC_EN to insert a two-flop synchronizer on RX_IN (adds two cycles of latency).
module uart_rx_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESCALE_W = 6
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic [PRESCALE_W-1:0] Prescale,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  data_valid,
   output logic                  par_err,
   output logic                  stp_err
);
   // state | meaning: IDLE wait for low line | START verify start bit | DATA shift bits | PARITY check | STOP check
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);
   localparam logic [PRESCALE_W-1:0] P8  = PRESCALE_W'(8);
   localparam logic [PRESCALE_W-1:0] P16 = PRESCALE_W'(16);
   localparam logic [PRESCALE_W-1:0] P32 = PRESCALE_W'(32);

   logic rx;
`ifdef RX_SYNC_EN
   logic [1:0] sync_q;
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) sync_q <= 2'b11;
      else     sync_q <= {sync_q[0], RX_IN};
   end
   assign rx = sync_q[1];
`else
   assign rx = RX_IN;
`endif

   state_t                  state_q, state_d;
   logic [PRESCALE_W-1:0]   edge_q, edge_d, p_q, p_d, p_dec;
   logic [BCW-1:0]          bit_q, bit_d;
   logic [DATA_WIDTH-1:0]   shift_q, shift_d, pdata_q, pdata_d;
   logic [2:0]              smp_q, smp_d;
   logic                    par_en_q, par_en_d, par_typ_q, par_typ_d;
   logic                    frame_err_q, frame_err_d, line_ok_q, line_ok_d;
   logic                    dv_q, dv_d, perr_q, perr_d, serr_q, serr_d;
   logic [PRESCALE_W-1:0]   half;
   logic                    at_s0, at_s1, at_s2, at_vote, at_end;
   logic                    vote, vote_early, start_ok, last_bit;

   assign p_dec      = (Prescale == P8 || Prescale == P16 || Prescale == P32) ? Prescale : P8;
   assign half       = p_q >> 1;
   assign at_s0      = (edge_q == half - ONE);
   assign at_s1      = (edge_q == half);
   assign at_s2      = (edge_q == half + ONE);
   assign at_vote    = (edge_q == half + ONE + ONE);
   assign at_end     = (edge_q == p_q - ONE);
   assign vote       = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);
   // Error pulses must be visible at P/2+2, so they use the third sample straight from the line.
   assign vote_early = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx) | (smp_q[1] & rx);
   assign start_ok   = ~rx & line_ok_q;
   assign last_bit   = (bit_q == BCW'(DATA_WIDTH - 1));

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= S_IDLE;
         edge_q      <= '0;
         p_q         <= P8;
         bit_q       <= '0;
         shift_q     <= '0;
         pdata_q     <= '0;
         smp_q       <= '0;
         par_en_q    <= 1'b0;
         par_typ_q   <= 1'b0;
         frame_err_q <= 1'b0;
         line_ok_q   <= 1'b1;
         dv_q        <= 1'b0;
         perr_q      <= 1'b0;
         serr_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         edge_q      <= edge_d;
         p_q         <= p_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         pdata_q     <= pdata_d;
         smp_q       <= smp_d;
         par_en_q    <= par_en_d;
         par_typ_q   <= par_typ_d;
         frame_err_q <= frame_err_d;
         line_ok_q   <= line_ok_d;
         dv_q        <= dv_d;
         perr_q      <= perr_d;
         serr_q      <= serr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (start_ok) state_d = S_START;
         S_START: begin
            if (at_vote && vote) state_d = S_IDLE;
            else if (at_end)     state_d = S_DATA;
         end
         S_DATA:   if (at_end && last_bit) state_d = par_en_q ? S_PARITY : S_STOP;
         S_PARITY: if (at_end) state_d = S_STOP;
         S_STOP:   if (at_end) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      edge_d      = edge_q;
      p_d         = p_q;
      bit_d       = bit_q;
      shift_d     = shift_q;
      pdata_d     = pdata_q;
      smp_d       = smp_q;
      par_en_d    = par_en_q;
      par_typ_d   = par_typ_q;
      frame_err_d = frame_err_q;
      line_ok_d   = line_ok_q;
      dv_d        = 1'b0;
      perr_d      = 1'b0;
      serr_d      = 1'b0;
      if (state_q == S_IDLE) begin
         edge_d = '0;
         bit_d  = '0;
         if (rx) line_ok_d = 1'b1;
         if (start_ok) begin
            edge_d      = ONE;
            p_d         = p_dec;
            par_en_d    = PAR_EN;
            par_typ_d   = PAR_TYP;
            frame_err_d = 1'b0;
         end
      end else begin
         edge_d = (at_end || state_d == S_IDLE) ? '0 : edge_q + ONE;
         if (at_s0) smp_d[0] = rx;
         if (at_s1) smp_d[1] = rx;
         if (at_s2) smp_d[2] = rx;
         case (state_q)
            S_DATA: if (at_end) begin
               shift_d = {vote, shift_q[DATA_WIDTH-1:1]};
               bit_d   = last_bit ? '0 : bit_q + BCW'(1);
            end
            S_PARITY: if (at_s2 && (vote_early != ((^shift_q) ^ par_typ_q))) begin
               perr_d      = 1'b1;
               frame_err_d = 1'b1;
            end
            S_STOP: begin
               if (at_s2 && !vote_early) begin
                  serr_d      = 1'b1;
                  frame_err_d = 1'b1;
                  line_ok_d   = 1'b0;
               end
               if (at_end && !frame_err_q) begin
                  dv_d    = 1'b1;
                  pdata_d = shift_q;
               end
            end
            default: ;
         endcase
      end
   end

   assign P_DATA     = pdata_q;
   assign data_valid = dv_q;
   assign par_err    = perr_q;
   assign stp_err    = serr_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: frame driver pushes predicted pulses, negedge monitor pops and compares.
module tb_uart_rx_ctrl;
   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       RX_IN = 1'b1;
   logic       PAR_EN = 1'b0;
   logic       PAR_TYP = 1'b0;
   logic [5:0] Prescale = 6'd8;
   logic [7:0] P_DATA;
   logic       data_valid, par_err, stp_err;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      int         kind;   // 0 data_valid, 1 par_err, 2 stp_err
      logic [7:0] data;
      int         at;
   } exp_t;
   exp_t       sb[$];
   logic [7:0] last_good = 8'h00;

   uart_rx_ctrl #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
      .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
      .Prescale(Prescale), .P_DATA(P_DATA), .data_valid(data_valid),
      .par_err(par_err), .stp_err(stp_err)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc = cyc + 1;

   initial begin
      #600000;
      $display("FAIL watchdog: run exceeded time limit at cycle %0d, required finish earlier", cyc);
      $fatal(1, "watchdog");
   end

   always @(negedge CLK) begin
      if (!RST && (data_valid || par_err || stp_err)) begin
         int   kind;
         exp_t e;
         checks++;
         if (int'(data_valid) + int'(par_err) + int'(stp_err) > 1) begin
            errors++;
            $display("FAIL exclusive: dv=%0b par=%0b stp=%0b at cycle %0d, required at most one", data_valid, par_err, stp_err, cyc);
         end
         kind = data_valid ? 0 : (par_err ? 1 : 2);
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse: kind %0d at cycle %0d, required no pulse", kind, cyc);
         end else begin
            e = sb.pop_front();
            checks++;
            if (e.kind != kind) begin
               errors++;
               $display("FAIL pulse_kind: got %0d at cycle %0d, required %0d", kind, cyc, e.kind);
            end
            checks++;
            if (e.at != cyc) begin
               errors++;
               $display("FAIL pulse_cycle: kind %0d at cycle %0d, required cycle %0d", kind, cyc, e.at);
            end
            checks++;
            if (P_DATA !== e.data) begin
               errors++;
               $display("FAIL p_data: got %02h, required %02h (cycle %0d)", P_DATA, e.data, cyc);
            end
         end
      end
   end

   task automatic hold(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   function automatic int eff_p(input int raw);
      return (raw == 8 || raw == 16 || raw == 32) ? raw : 8;
   endfunction

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %02h, required %02h", name, got, want);
      end
   endtask

   // Caller is #1 after a posedge; the current cycle becomes cycle 0 of the start bit.
   task automatic send_frame(input logic [7:0] data, input int raw, input bit pe, input bit pt,
                             input bit par_ok, input bit stop_bit, input bit scramble);
      int   p, c, n;
      logic parb;
      exp_t e;
      p    = eff_p(raw);
      parb = (^data) ^ pt;
      if (!par_ok) parb = ~parb;
      Prescale = 6'(raw);
      PAR_EN   = pe;
      PAR_TYP  = pt;
      RX_IN    = 1'b0;
      c        = cyc;
      n        = 1 + 8 + int'(pe) + 1;
      if (pe && !par_ok) begin
         e.kind = 1; e.data = last_good; e.at = c + 9 * p + p / 2 + 2;
         sb.push_back(e);
      end
      if (!stop_bit) begin
         e.kind = 2; e.data = last_good; e.at = c + (9 + int'(pe)) * p + p / 2 + 2;
         sb.push_back(e);
      end
      if ((!pe || par_ok) && stop_bit) begin
         last_good = data;
         e.kind = 0; e.data = data; e.at = c + n * p;
         sb.push_back(e);
      end
      hold(1);
      if (scramble) begin
         Prescale = 6'($urandom_range(0, 63));
         PAR_EN   = 1'($urandom_range(0, 1));
         PAR_TYP  = 1'($urandom_range(0, 1));
      end
      hold(p - 1);
      for (int i = 0; i < 8; i++) begin
         RX_IN = data[i];
         hold(p);
      end
      if (pe) begin
         RX_IN = parb;
         hold(p);
      end
      RX_IN = stop_bit;
      hold(p);
      RX_IN = 1'b1;
   endtask

   initial begin
      int  raw, gap;
      bit  prev_stop_bad;
      hold(3);
      check("reset_p_data", P_DATA, 8'h00);
      check("reset_data_valid", {7'd0, data_valid}, 8'h00);
      check("reset_par_err", {7'd0, par_err}, 8'h00);
      check("reset_stp_err", {7'd0, stp_err}, 8'h00);
      RST = 1'b0;
      hold(3);

      send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      send_frame(8'hA5, 8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      hold(2);
      send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      RX_IN = 1'b0;               // line stays low after the stop error: no new frame may start
      hold(48);
      RX_IN = 1'b1;
      hold(2);

      Prescale = 6'd8; PAR_EN = 1'b0;
      RX_IN = 1'b0;
      hold(2);
      RX_IN = 1'b1;
      hold(5);
      send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      hold(1);

      send_frame(8'h01, 32, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      send_frame(8'hFE, 32, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      hold(2);

      Prescale = 6'd8; PAR_EN = 1'b0;
      RX_IN = 1'b0;
      hold(8);
      for (int i = 0; i < 4; i++) begin
         RX_IN = (i % 2 == 0);
         hold(8);
      end
      RX_IN = 1'b1;
      hold(3);
      RST = 1'b1;
      #1;
      check("midreset_p_data", P_DATA, 8'h00);
      check("midreset_data_valid", {7'd0, data_valid}, 8'h00);
      check("midreset_par_err", {7'd0, par_err}, 8'h00);
      check("midreset_stp_err", {7'd0, stp_err}, 8'h00);
      last_good = 8'h00;
      hold(3);
      RST = 1'b0;
      hold(2);
      send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

      prev_stop_bad = 1'b0;
      for (int k = 0; k < 24; k++) begin
         bit stop_ok;
         case ($urandom_range(0, 4))
            0:       raw = 8;
            1:       raw = 16;
            2:       raw = 32;
            default: raw = int'($urandom_range(0, 63));
         endcase
         gap = int'($urandom_range(0, 2));
         if (prev_stop_bad && gap == 0) gap = 1;
         hold(gap);
         stop_ok = ($urandom_range(0, 5) != 0);
         send_frame(8'($urandom_range(0, 255)), raw, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 5) != 0), stop_ok, 1'b1);
         prev_stop_bad = !stop_ok;
      end

      hold(40);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL missing_pulses: %0d still pending, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
